// File: rtl/sbus_master_port.sv
// sbus initiator: serializes host read/write requests (single or burst)
// onto the bit-serial memory bus and deserializes returned read beats.
module sbus_master_port #(
   parameter int N       = 8,
   parameter int ADN     = 12,
   parameter int BN      = 3,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_wren,
   input  logic           req_burst,
   input  logic [ADN-1:0] req_addr,
   input  logic [N-1:0]   req_wdata,
   input  logic [BN-1:0]  req_blen,
   input  logic           wbeat_valid,
   input  logic [N-1:0]   wbeat_data,
   output logic           wbeat_ready,
   output logic           rsp_valid,
   output logic [N-1:0]   rsp_data,
   output logic           rsp_last,
   output logic           done,
   output logic           err,
   output logic           bus_valid,
   output logic           bus_wren,
   output logic           bus_addr,
   output logic           bus_data,
   output logic           bus_burst,
   input  logic           slv_valid,
   input  logic           slv_data
);
   localparam int MAXC = (TIMEOUT > ADN) ? TIMEOUT : ADN;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] ADDR_LAST  = CW'(ADN - 1);
   localparam logic [CW-1:0] DATA_START = CW'(ADN - N);
   localparam logic [CW-1:0] BLEN_START = CW'(ADN - BN);
   localparam logic [CW-1:0] DATA_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(2);

   typedef enum logic [2:0] {
      IDLE, REQ, ADDR, WGAP, WDATA, RWAIT, RDATA, DONE
   } state_t;

   state_t state, nextState;

   logic           wrenQ, burstQ, errQ;
   logic [BN-1:0]  blenQ, blenSh;
   logic [ADN-1:0] addrSh;
   logic [N-1:0]   wdSh;
   logic [N-2:0]   rdSh;
   logic [CW-1:0]  cnt;
   logic [9:0]     beatCnt, beatTotal;
   logic           accept, cntClr, cntInc, loadBeat, beatInc;
   logic           rdShift, setErr, rspFire;
   logic           lastBeat, rdLast;
   logic           addrShift, wdShift, blenShift;

   assign beatTotal = 10'd4 << blenQ;
   assign lastBeat  = !burstQ || (beatCnt == beatTotal);
   assign rdLast    = !burstQ || ((beatCnt + 10'd1) == beatTotal);

   assign addrShift = (state == ADDR);
   assign wdShift   = (state == WDATA) ||
                      ((state == ADDR) && wrenQ && (cnt >= DATA_START));
   assign blenShift = (state == ADDR) && (cnt >= BLEN_START);

   // last read bit is forwarded straight from the pin so the word
   // is presented in the same cycle it completes
   assign rsp_valid = rspFire;
   assign rsp_last  = rspFire && rdLast;
   assign rsp_data  = rspFire ? {rdSh, slv_data} : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState   = state;
      req_ready   = 1'b0;
      bus_valid   = 1'b0;
      bus_wren    = 1'b0;
      bus_addr    = 1'b0;
      bus_data    = 1'b0;
      bus_burst   = 1'b0;
      wbeat_ready = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      accept      = 1'b0;
      cntClr      = 1'b0;
      cntInc      = 1'b0;
      loadBeat    = 1'b0;
      beatInc     = 1'b0;
      rdShift     = 1'b0;
      setErr      = 1'b0;
      rspFire     = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) nextState = REQ;
         end
         REQ: begin
            bus_valid = 1'b1;
            bus_wren  = wrenQ;
            bus_burst = burstQ;
            cntClr    = 1'b1;
            nextState = ADDR;
         end
         ADDR: begin
            bus_valid = 1'b1;
            bus_wren  = wrenQ;
            bus_addr  = addrSh[ADN-1];
            bus_data  = wrenQ && (cnt >= DATA_START) && wdSh[N-1];
            bus_burst = burstQ && (cnt >= BLEN_START) && blenSh[BN-1];
            cntInc    = 1'b1;
            if (cnt == ADDR_LAST) begin
               cntClr = 1'b1;
               if (wrenQ) begin
                  beatInc   = 1'b1;
                  nextState = WGAP;
               end else begin
                  nextState = RWAIT;
               end
            end
         end
         WGAP: begin
            // counter parks at GAP_LAST while waiting for the next word
            if (cnt != GAP_LAST) begin
               cntInc = 1'b1;
            end else if (lastBeat) begin
               nextState = DONE;
            end else if (wbeat_valid) begin
               wbeat_ready = 1'b1;
               loadBeat    = 1'b1;
               cntClr      = 1'b1;
               nextState   = WDATA;
            end
         end
         WDATA: begin
            bus_valid = 1'b1;
            bus_wren  = 1'b1;
            bus_data  = wdSh[N-1];
            cntInc    = 1'b1;
            if (cnt == DATA_LAST) begin
               cntClr    = 1'b1;
               beatInc   = 1'b1;
               nextState = WGAP;
            end
         end
         RWAIT: begin
            cntInc = 1'b1;
            if (slv_valid) begin
               cntClr    = 1'b1;
               nextState = RDATA;
            end else if (cnt == TO_LAST) begin
               setErr    = 1'b1;
               nextState = DONE;
            end
         end
         RDATA: begin
            if (slv_valid) begin
               rdShift = 1'b1;
               cntInc  = 1'b1;
               if (cnt == DATA_LAST) begin
                  cntClr    = 1'b1;
                  beatInc   = 1'b1;
                  rspFire   = 1'b1;
                  nextState = rdLast ? DONE : RWAIT;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            err       = errQ;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrenQ   <= 1'b0;
         burstQ  <= 1'b0;
         errQ    <= 1'b0;
         blenQ   <= '0;
         blenSh  <= '0;
         addrSh  <= '0;
         wdSh    <= '0;
         rdSh    <= '0;
         cnt     <= '0;
         beatCnt <= '0;
      end else begin
         if (accept) begin
            wrenQ   <= req_wren;
            burstQ  <= req_burst;
            blenQ   <= req_blen;
            blenSh  <= req_blen;
            addrSh  <= req_addr;
            wdSh    <= req_wdata;
            beatCnt <= '0;
            errQ    <= 1'b0;
         end else begin
            if (addrShift) addrSh <= addrSh << 1;
            if (blenShift) blenSh <= blenSh << 1;
            if (loadBeat)     wdSh <= wbeat_data;
            else if (wdShift) wdSh <= wdSh << 1;
            if (beatInc) beatCnt <= beatCnt + 10'd1;
            if (setErr)  errQ <= 1'b1;
         end
         if (cntClr)      cnt <= '0;
         else if (cntInc) cnt <= cnt + 1'b1;
         if (rdShift) rdSh <= {rdSh[N-3:0], slv_data};
      end
   end
endmodule

// File: tb/tb_sbus_master_port.sv
// Directed bench for sbus_master_port: write, read, bursts,
// read timeout and mid-transaction reset.
module tb_sbus_master_port;
   localparam int N = 8, ADN = 12, BN = 3, TIMEOUT = 64;

   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_ready, req_wren, req_burst;
   logic [ADN-1:0] req_addr;
   logic [N-1:0] req_wdata;
   logic [BN-1:0] req_blen;
   logic wbeat_valid, wbeat_ready;
   logic [N-1:0] wbeat_data;
   logic rsp_valid, rsp_last, done, err;
   logic [N-1:0] rsp_data;
   logic bus_valid, bus_wren, bus_addr, bus_data, bus_burst;
   logic slv_valid, slv_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sbus_master_port #(.N(N), .ADN(ADN), .BN(BN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wren(req_wren), .req_burst(req_burst),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_blen(req_blen),
      .wbeat_valid(wbeat_valid), .wbeat_data(wbeat_data),
      .wbeat_ready(wbeat_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .err(err),
      .bus_valid(bus_valid), .bus_wren(bus_wren), .bus_addr(bus_addr),
      .bus_data(bus_data), .bus_burst(bus_burst),
      .slv_valid(slv_valid), .slv_data(slv_data)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // called at an IDLE negedge; returns at the REQ negedge
   task automatic request(input logic w, input logic b,
                          input logic [ADN-1:0] a, input logic [N-1:0] d,
                          input logic [BN-1:0] bl);
      req_valid = 1'b1; req_wren = w; req_burst = b;
      req_addr = a; req_wdata = d; req_blen = bl;
      #1 chk("idle_ready", req_ready, 1);
      cyc();
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_blen = ~bl;
      req_wren = ~w; req_burst = ~b;
      #1;
      chk("req_valid", bus_valid, 1);
      chk("req_wren", bus_wren, w);
      chk("req_burst", bus_burst, b);
      chk("req_busy", req_ready, 0);
   endtask

   task automatic sendAddr(output logic [ADN-1:0] a, output logic [ADN-1:0] d,
                           output logic [ADN-1:0] b, output logic [ADN-1:0] w,
                           output logic v);
      a = '0; d = '0; b = '0; w = '0; v = 1'b1;
      for (int i = 0; i < ADN; i++) begin
         cyc(); #1;
         a = {a[ADN-2:0], bus_addr};
         d = {d[ADN-2:0], bus_data};
         b = {b[ADN-2:0], bus_burst};
         w = {w[ADN-2:0], bus_wren};
         v = v & bus_valid;
      end
   endtask

   task automatic waitDone(input int maxc, output int k, output logic e,
                           output logic anyV);
      k = -1; e = 1'b0; anyV = 1'b0;
      for (int i = 1; i <= maxc; i++) begin
         cyc(); #1;
         if (done) begin
            k = i; e = err;
            break;
         end
         anyV = anyV | bus_valid;
      end
   endtask

   // starts at an RWAIT negedge; returns at the negedge after the beat
   task automatic readBeat(input logic [N-1:0] w, input int stallAt,
                           output logic v, output logic [N-1:0] d,
                           output logic l, output int early);
      early = 0; v = 1'b0; d = '0; l = 1'b0;
      slv_valid = 1'b1; slv_data = ~w[N-1];
      #1 early += int'(rsp_valid);
      for (int i = 0; i < N; i++) begin
         cyc();
         if (i == stallAt) begin
            slv_valid = 1'b0; slv_data = 1'b1;
            #1 early += int'(rsp_valid);
            cyc();
         end
         slv_valid = 1'b1; slv_data = w[N-1-i];
         #1;
         if (i == N - 1) begin
            v = rsp_valid; d = rsp_data; l = rsp_last;
         end else begin
            early += int'(rsp_valid);
         end
      end
      cyc();
      slv_valid = 1'b0; slv_data = 1'b0;
      #1;
   endtask

   initial begin
      logic [ADN-1:0] a, d, b, w;
      logic v, e, anyV, rv, rl;
      logic [N-1:0] rd;
      logic [7:0] lastMask;
      logic [23:0] cap;
      logic [N-1:0] rwords [8];
      logic [N-1:0] wwords [3];
      int k, early, pulses, firstAt, nbits, bi, earlySum, doneSum;

      rwords = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hC3, 8'h3C, 8'h7E, 8'hA5};
      wwords = '{8'h22, 8'h33, 8'h44};

      reset = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_burst = 1'b0;
      req_addr = '0; req_wdata = '0; req_blen = '0;
      wbeat_valid = 1'b0; wbeat_data = '0;
      slv_valid = 1'b0; slv_data = 1'b0;
      cyc(); cyc(); #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_bus", {bus_valid, bus_wren, bus_addr, bus_data, bus_burst}, 0);
      chk("rst_outs", {wbeat_ready, rsp_valid, rsp_last, done, err}, 0);
      chk("rst_rdata", rsp_data, 0);
      reset = 1'b0;
      cyc();

      // single write; blen must be ignored
      request(1'b1, 1'b0, 12'hA5C, 8'h3C, 3'd5);
      sendAddr(a, d, b, w, v);
      chk("w1_addr", a, 12'hA5C);
      chk("w1_data", d, 12'h03C);
      chk("w1_burst", b, 12'h000);
      chk("w1_wren", w, 12'hFFF);
      chk("w1_valid", v, 1);
      waitDone(10, k, e, anyV);
      chk("w1_done_at", k, 4);
      chk("w1_err", e, 0);
      chk("w1_gap_idle", anyV, 0);
      cyc(); #1;
      chk("w1_back_idle", {req_ready, done}, 2'b10);

      // single read returning 0x96
      request(1'b0, 1'b0, 12'h001, 8'hFF, 3'd0);
      sendAddr(a, d, b, w, v);
      chk("r1_addr", a, 12'h001);
      chk("r1_data", d, 12'h000);
      chk("r1_wren", w, 12'h000);
      cyc();
      readBeat(8'h96, -1, rv, rd, rl, early);
      chk("r1_rsp_valid", rv, 1);
      chk("r1_rsp_data", rd, 8'h96);
      chk("r1_rsp_last", rl, 1);
      chk("r1_early", early, 0);
      chk("r1_done", {done, err, rsp_valid}, 3'b100);
      cyc();

      // burst write, blen=0: 4 beats
      request(1'b1, 1'b1, 12'h100, 8'h11, 3'd0);
      sendAddr(a, d, b, w, v);
      chk("bw_addr", a, 12'h100);
      chk("bw_data", d, 12'h011);
      chk("bw_burst", b, 12'h000);
      bi = 0; pulses = 0; firstAt = -1; cap = '0; nbits = 0; k = -1;
      for (int i = 1; i <= 200; i++) begin
         cyc();
         wbeat_valid = (bi < 3);
         wbeat_data = (bi < 3) ? wwords[bi] : 8'h00;
         #1;
         if (wbeat_ready) begin
            pulses++;
            if (firstAt < 0) firstAt = i;
            bi++;
         end
         if (bus_valid) begin
            cap = {cap[22:0], bus_data};
            nbits++;
         end
         if (done) begin
            k = i;
            break;
         end
      end
      wbeat_valid = 1'b0;
      chk("bw_pulses", pulses, 3);
      chk("bw_first_ready", firstAt, 3);
      chk("bw_nbits", nbits, 24);
      chk("bw_words", cap, 24'h223344);
      chk("bw_done_at", k, 37);
      cyc();

      // burst read, blen=1: 8 beats with a stall in beat 2
      request(1'b0, 1'b1, 12'h2F0, 8'h00, 3'd1);
      sendAddr(a, d, b, w, v);
      chk("br_addr", a, 12'h2F0);
      chk("br_burst", b, 12'h001);
      cyc();
      lastMask = '0; earlySum = 0; doneSum = 0; pulses = 0;
      for (int i = 0; i < 8; i++) begin
         readBeat(rwords[i], (i == 2) ? 4 : -1, rv, rd, rl, early);
         chk($sformatf("br_word%0d", i), rd, rwords[i]);
         lastMask[i] = rl;
         pulses += int'(rv);
         earlySum += early;
         if (i < 7) doneSum += int'(done);
      end
      chk("br_pulses", pulses, 8);
      chk("br_last_mask", lastMask, 8'h80);
      chk("br_early", earlySum, 0);
      chk("br_no_early_done", doneSum, 0);
      chk("br_done", {done, err}, 2'b10);
      cyc();

      // read timeout
      request(1'b0, 1'b0, 12'h7FF, 8'h00, 3'd0);
      sendAddr(a, d, b, w, v);
      chk("to_addr", a, 12'h7FF);
      waitDone(TIMEOUT + 8, k, e, anyV);
      chk("to_done_at", k, TIMEOUT + 1);
      chk("to_err", e, 1);
      cyc(); #1;
      chk("to_err_pulse", {err, done, req_ready}, 3'b001);

      // reset during the second beat's WDATA
      request(1'b1, 1'b1, 12'h0F0, 8'hAA, 3'd0);
      sendAddr(a, d, b, w, v);
      wbeat_valid = 1'b1; wbeat_data = 8'h55;
      cyc(); cyc(); cyc(); #1;
      chk("rs_wbeat_ready", wbeat_ready, 1);
      cyc(); wbeat_valid = 1'b0;
      cyc(); #1;
      chk("rs_in_wdata", {bus_valid, bus_wren}, 2'b11);
      reset = 1'b1;
      cyc(); #1;
      chk("rs_bus", {bus_valid, bus_wren, bus_addr, bus_data, bus_burst}, 0);
      chk("rs_ready", {req_ready, done}, 2'b10);
      reset = 1'b0;
      doneSum = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(); #1;
         doneSum += int'(done);
      end
      chk("rs_no_done", doneSum, 0);
      request(1'b1, 1'b0, 12'h5A3, 8'hC7, 3'd0);
      sendAddr(a, d, b, w, v);
      chk("rs_new_addr", a, 12'h5A3);
      chk("rs_new_data", d, 12'h0C7);
      waitDone(10, k, e, anyV);
      chk("rs_new_done_at", k, 4);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
